// File: rtl/framing_pkg.sv
// Shared framing constants and state encoding for the framer and deframer.
// Both ends must agree on the header bytes for the link to synchronise.
package framing_pkg;

   localparam logic [7:0] HEADER_BYTE0 = 8'hA5;
   localparam logic [7:0] HEADER_BYTE1 = 8'h5A;

   typedef enum logic [1:0] {
      Idle,
      Hdr0,
      Hdr1,
      Payload
   } framer_state_e;

endpackage

// File: rtl/framer_packer.sv
// Packs PackedNum narrow elements LSB-first into one output word.
// A full word drains and a new element refills it in the same cycle.
module framer_packer #(
   parameter int unsigned UnpackedWidth = 1,
   parameter int unsigned PackedNum     = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               en_i,
   input  logic                               valid_i,
   input  logic [UnpackedWidth-1:0]           unpacked_i,
   input  logic                               ready_i,
   input  logic                               last_byte_i,
   output logic                               ready_o,
   output logic                               full_o,
   output logic                               out_fire_o,
   output logic [UnpackedWidth*PackedNum-1:0] pack_o
);

   localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;
   localparam int unsigned CntW        = $clog2(PackedNum + 1);

   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [PackedWidth-1:0] pack_q, pack_d;
   logic                   in_fire;

   assign full_o     = (cnt_q == CntW'(PackedNum));
   assign out_fire_o = en_i && full_o && ready_i;
   // The last byte of a packet must not pull in an element of the next packet.
   assign ready_o    = en_i && (!full_o || (ready_i && !last_byte_i));
   assign in_fire    = valid_i && ready_o;
   assign pack_o     = pack_q;

   always_comb begin
      cnt_d  = cnt_q;
      pack_d = pack_q;
      if (out_fire_o) begin
         cnt_d  = '0;
         pack_d = '0;
      end
      if (in_fire) begin
         for (int k = 0; k < PackedNum; k++) begin
            if (cnt_d == CntW'(k)) begin
               pack_d[k*UnpackedWidth +: UnpackedWidth] = unpacked_i;
            end
         end
         cnt_d = cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         pack_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pack_q <= pack_d;
      end
   end

endmodule

// File: rtl/framer.sv
// Packet framer: two header bytes followed by a fixed number of packed payload bytes.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   Idle    | no packet in flight; leave on first pending element
//   Hdr0    | presenting first header byte
//   Hdr1    | presenting second header byte
//   Payload | packing elements and emitting payload bytes
module framer
   import framing_pkg::*;
#(
   parameter int unsigned UnpackedWidth  = 1,
   parameter int unsigned PackedNum      = 8,
   parameter int unsigned PacketLenBytes = 1024,
   parameter logic [UnpackedWidth*PackedNum-1:0] HeaderByte0 = HEADER_BYTE0,
   parameter logic [UnpackedWidth*PackedNum-1:0] HeaderByte1 = HEADER_BYTE1
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic [UnpackedWidth-1:0]           unpacked_i,
   output logic                               valid_o,
   input  logic                               ready_i,
   output logic [UnpackedWidth*PackedNum-1:0] data_o,
   output logic                               frame_done_o
);

   localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;
   localparam int unsigned ByteCntW    = $clog2(PacketLenBytes);

   framer_state_e state_q, state_d;
   logic [ByteCntW-1:0]    byte_cnt_q;
   logic                   frame_done_q;
   logic                   last_byte;
   logic                   in_payload;
   logic                   pk_ready;
   logic                   pk_full;
   logic                   pk_out_fire;
   logic [PackedWidth-1:0] pk_data;

   assign in_payload = (state_q == Payload);
   assign last_byte  = (byte_cnt_q == ByteCntW'(PacketLenBytes - 1));

   framer_packer #(
      .UnpackedWidth (UnpackedWidth),
      .PackedNum     (PackedNum)
   ) u_packer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (in_payload),
      .valid_i     (valid_i),
      .unpacked_i  (unpacked_i),
      .ready_i     (ready_i),
      .last_byte_i (last_byte),
      .ready_o     (pk_ready),
      .full_o      (pk_full),
      .out_fire_o  (pk_out_fire),
      .pack_o      (pk_data)
   );

   assign ready_o      = pk_ready;
   assign frame_done_o = frame_done_q;

   always_comb begin
      state_d = state_q;
      valid_o = 1'b0;
      data_o  = '0;
      unique case (state_q)
         Idle: begin
            if (valid_i) state_d = Hdr0;
         end
         Hdr0: begin
            valid_o = 1'b1;
            data_o  = HeaderByte0;
            if (ready_i) state_d = Hdr1;
         end
         Hdr1: begin
            valid_o = 1'b1;
            data_o  = HeaderByte1;
            if (ready_i) state_d = Payload;
         end
         Payload: begin
            valid_o = pk_full;
            data_o  = pk_data;
            if (pk_out_fire && last_byte) state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= Idle;
         byte_cnt_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= pk_out_fire && last_byte;
         if (pk_out_fire) begin
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_framer.sv
// Randomised bench for framer: expected byte stream is built from the offered
// element sequence and checked on every output handshake.
module tb_framer;

   localparam int UW  = 2;
   localparam int PN  = 4;
   localparam int PLB = 4;
   localparam int EPP = PN * PLB;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [UW-1:0] unpacked_i = '0;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic [7:0]    data_o;
   logic          frame_done_o;

   framer #(
      .UnpackedWidth  (UW),
      .PackedNum      (PN),
      .PacketLenBytes (PLB)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .unpacked_i   (unpacked_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .data_o       (data_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   int         n_cmp  = 0;
   int         n_fail = 0;
   int         stim_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         stim_idx;
   int         out_idx;
   int         done_cnt;
   bit         exp_done;
   bit         prev_stall;
   logic [7:0] prev_data;
   bit         mon_en = 0;
   bit         rnd_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Model: headers open every packet that has at least one element pending,
   // each complete group of PN elements becomes one LSB-first byte.
   task automatic build_phase(input int n, input bit random_vals, input bit rr);
      logic [7:0] b;
      stim_q.delete(); exp_q.delete(); got_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(random_vals ? int'($urandom_range(0, 3)) : i % 4);
      for (int i = 0; i < n; i += PN) begin
         if (i % EPP == 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
         end
         if (i + PN <= n) begin
            b = '0;
            for (int k = 0; k < PN; k++) b = b | (8'(stim_q[i+k]) << (k * UW));
            exp_q.push_back(b);
         end
      end
      stim_idx = 0; out_idx = 0; done_cnt = 0;
      exp_done = 0; prev_stall = 0; rnd_ready = rr;
   endtask

   task automatic apply_inputs();
      valid_i    = (stim_idx < stim_q.size());
      unpacked_i = valid_i ? UW'(stim_q[stim_idx]) : '0;
      ready_i    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic drive(input int budget, input int stop_out);
      bit ok;
      ok = 0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk_i); #1;
         apply_inputs();
         if ((stop_out >= 0 && out_idx >= stop_out) ||
             (stop_out < 0 && stim_idx == stim_q.size() && out_idx == exp_q.size())) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout: stim %0d/%0d out %0d/%0d", stim_idx, stim_q.size(), out_idx, exp_q.size());
      end
   endtask

   task automatic settle();
      repeat (3) begin
         @(posedge clk_i); #1;
         apply_inputs();
      end
   endtask

   always @(negedge clk_i) begin
      if (mon_en) begin
         check("frame_done", frame_done_o, exp_done);
         if (frame_done_o) done_cnt++;
         exp_done = 0;
         if (prev_stall) begin
            check("stall_valid", valid_o, 1'b1);
            check("stall_data", data_o, prev_data);
         end
         if (valid_i && ready_o) begin
            n_cmp++;
            if (out_idx < (stim_idx / EPP) * (PLB + 2) + 2) begin
               n_fail++;
               $display("FAIL early_accept: element %0d taken with %0d bytes out", stim_idx, out_idx);
            end
            stim_idx++;
         end
         if (valid_o && ready_i) begin
            if (out_idx >= exp_q.size()) begin
               n_cmp++; n_fail++;
               $display("FAIL extra_byte: got %0h expected none", data_o);
            end else begin
               check("data", data_o, exp_q[out_idx]);
            end
            got_q.push_back(data_o);
            if (out_idx % (PLB + 2) == PLB + 1) exp_done = 1;
            out_idx++;
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
      end
   end

   task automatic do_reset();
      mon_en = 0;
      valid_i = 0; ready_i = 0;
      @(posedge clk_i); #3;
      rst_ni = 0;
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1;
   endtask

   initial begin
      // Reset and idle
      repeat (3) @(posedge clk_i);
      #2 rst_ni = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_i);
         check("idle_valid", valid_o, 1'b0);
         check("idle_ready", ready_o, 1'b0);
         check("idle_done", frame_done_o, 1'b0);
      end

      // Basic packet
      build_phase(16, 0, 0);
      check("model_byte", exp_q[2], 8'hE4);
      mon_en = 1;
      drive(2000, -1);
      settle();
      check("basic_count", got_q.size(), 6);
      if (got_q.size() == 6) begin
         check("basic_h0", got_q[0], 8'hA5);
         check("basic_h1", got_q[1], 8'h5A);
         for (int i = 2; i < 6; i++) check("basic_pay", got_q[i], 8'hE4);
      end
      check("basic_done_pulses", done_cnt, 1);

      // Backpressure
      build_phase(16, 0, 1);
      drive(4000, -1);
      settle();
      check("bp_count", got_q.size(), 6);
      check("bp_done_pulses", done_cnt, 1);

      // Long random stream with random backpressure
      build_phase(1024, 1, 1);
      drive(20000, -1);
      settle();
      check("rand_count", got_q.size(), 64 * (PLB + 2));
      check("rand_done_pulses", done_cnt, 64);

      // Packet boundary: 20 back-to-back elements
      build_phase(20, 0, 0);
      drive(2000, -1);
      settle();
      check("bnd_count", got_q.size(), 9);
      if (got_q.size() == 9) begin
         check("bnd_h0", got_q[6], 8'hA5);
         check("bnd_h1", got_q[7], 8'h5A);
         check("bnd_slot0", got_q[8][1:0], 2'd0);
      end

      // Async reset mid-payload
      do_reset();
      build_phase(16, 0, 0);
      mon_en = 1;
      drive(2000, 4);
      mon_en = 0;
      #3 rst_ni = 0;
      #1;
      check("rst_valid", valid_o, 1'b0);
      check("rst_ready", ready_o, 1'b0);
      check("rst_done", frame_done_o, 1'b0);
      valid_i = 0; ready_i = 0;
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1;
      build_phase(16, 1, 1);
      mon_en = 1;
      drive(4000, -1);
      settle();
      check("post_rst_count", got_q.size(), 6);
      if (got_q.size() >= 2) begin
         check("post_rst_h0", got_q[0], 8'hA5);
         check("post_rst_h1", got_q[1], 8'h5A);
      end
      mon_en = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/framer.md
Name: framer

Overview:
- Transmit-side mirror of the deframer: accepts a stream of narrow unpacked elements and packs PackedNum of them into each byte.
- Emits each packet as a two-byte header (0xA5, 0x5A) followed by exactly PacketLenBytes payload bytes.
- Sits upstream of the UART TX / deframer path, e.g. the FPGA-to-ESP return channel or a loopback test harness.
- Its byte stream is consumed bit-exactly by the deframer with matching parameters.

Parameters:
- UnpackedWidth, 1, bits per input element.
- PackedNum, 8, elements per output byte; PackedWidth = UnpackedWidth*PackedNum (localparam).
- PacketLenBytes, 1024, payload bytes per packet; must be >= 2.
- HeaderByte0, 8'hA5, first header byte (PackedWidth wide).
- HeaderByte1, 8'h5A, second header byte (PackedWidth wide).

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, asynchronous, active-low; deassertion is synchronised to clk_i externally.
- valid_i  in  1  input element valid.
- ready_o  out  1  input element accepted when valid_i && ready_o (in_fire).
- unpacked_i  in  UnpackedWidth  input element.
- valid_o  out  1  output byte valid.
- ready_i  in  1  downstream ready; out_fire = valid_o && ready_i.
- data_o  out  PackedWidth  output byte.
- frame_done_o  out  1  one-cycle pulse, registered, the cycle after the last payload byte fires.

Behaviour:
- Reset, async on rst_ni low:
  - state = Idle; element count = 0; byte count = 0; pack register = 0.
  - Outputs: valid_o = 0, ready_o = 0, data_o = 0, frame_done_o = 0.
  - Assertion mid-packet aborts it; no partial-packet recovery.
- FSM states: Idle, Hdr0, Hdr1, Payload.
- Idle:
  - ready_o = 0, valid_o = 0, data_o = 0.
  - valid_i high -> Hdr0 next cycle. The element is not consumed; headers are sent only when data is pending.
- Hdr0:
  - valid_o = 1, data_o = HeaderByte0, ready_o = 0.
  - out_fire -> Hdr1.
- Hdr1:
  - valid_o = 1, data_o = HeaderByte1, ready_o = 0.
  - out_fire -> Payload.
- Payload, packing:
  - Element k of a byte (k = 0..PackedNum-1) lands at bits [k*UnpackedWidth +: UnpackedWidth], LSB-first, matching the unpacker.
  - pack_full = (element count == PackedNum).
  - valid_o = pack_full; data_o = pack register.
  - valid_o, once high, holds data_o stable until out_fire.
- Payload, input ready:
  - ready_o = !pack_full || (ready_i && byte count != PacketLenBytes-1).
  - This gives full throughput: an element is accepted in the same cycle the previous byte drains.
  - In the last byte of a packet, ready_o drops once full. No elements of the next packet are absorbed.
- Payload, simultaneous in_fire and out_fire while full:
  - The new element goes to slot 0 of a fresh byte; element count = 1; other bits cleared.
- Payload, counters:
  - Byte count increments on each payload out_fire.
  - Width is $clog2(PacketLenBytes); compare against PacketLenBytes-1; never wraps within a packet.
- End of packet:
  - out_fire with byte count == PacketLenBytes-1 -> Idle.
  - Counters clear; frame_done_o = 1 on the next cycle.
  - If valid_i is already high in Idle, Hdr0 follows one cycle later, so there is a minimum one-cycle gap between packets.
- Backpressure: ready_i low in any state stalls with all outputs stable; no bytes are dropped or duplicated.
- Latency: first element accepted to first payload byte valid is PackedNum accepts plus 0 cycles (combinational from the pack register).
- Header values are not escaped in the payload; framing relies on fixed length.

Decomposition:
- Shared package framing_pkg, also imported by the deframer:
  - HEADER_BYTE0 / HEADER_BYTE1 constants.
  - framer_state_e enum {Idle, Hdr0, Hdr1, Payload}.
- Sub-module packer (inverse of the existing unpacker):
  - Owns the pack register, element count, the valid/ready handshake and the LSB-first placement.
- The framer top owns the FSM, byte counter, header muxing and frame_done_o.

Test Plan:
Test parameters are UnpackedWidth=2, PackedNum=4, PacketLenBytes=4.
1. Reset/idle: hold rst_ni low, then release with valid_i=0 for 10 cycles -> valid_o=0, ready_o=0, frame_done_o=0 throughout.
2. Basic packet: stream elements 0,1,2,3 repeated 4 times (16 elements), ready_i=1 -> data_o sequence A5, 5A, E4, E4, E4, E4; frame_done_o pulses once, one cycle after the 4th E4.
3. Backpressure: same stimulus with ready_i toggled pseudo-randomly -> identical byte sequence, data_o stable while valid_o && !ready_i, no extra bytes.
4. Packet boundary: 20 elements presented back-to-back -> after the 4th payload byte ready_o=0 until Hdr0/Hdr1 of packet 2 complete; the 17th element (value 0) lands at byte bits [1:0].
5. Async reset mid-payload: assert rst_ni low after the 2nd payload byte, asynchronously between edges -> valid_o and ready_o drop immediately; the next packet starts with A5, 5A.
6. Loopback: connect to deframer with matching parameters, 1024 random elements -> deframer output equals framer input, in order.
